// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced, edge-detected push-button front end producing exclusive one-cycle S/R pulses
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int RESET_WINS      = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_BTN,
    input  logic CLR_BTN,
    output logic S,
    output logic R,
    output logic CONFLICT
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic RW = (RESET_WINS != 0);
    logic [1:0] meta_q, sync_q, stable_q, stable_d, dly_q, evt;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic s_d, r_d, c_d;
    // per channel (0 = set, 1 = clear): level flips only after DEBOUNCE_CYCLES differing samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == LAST) stable_d[i] = sync_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        evt = stable_q & ~dly_q;
        c_d = &evt;
        s_d = evt[0] & ~(c_d & RW);
        r_d = evt[1] & ~(c_d & ~RW);
    end
    // synchronizers, debounce state, edge-detect delay and output pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            dly_q    <= '0;
            cnt_q    <= '{default: '0};
            S        <= 1'b0;
            R        <= 1'b0;
            CONFLICT <= 1'b0;
        end else begin
            meta_q   <= {CLR_BTN, SET_BTN};
            sync_q   <= meta_q;
            stable_q <= stable_d;
            dly_q    <= stable_q;
            cnt_q    <= cnt_d;
            S        <= s_d;
            R        <= r_d;
            CONFLICT <= c_d;
        end
    end
endmodule
